sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Message-schedule generator for the SHA-256 hash core: accepts one 512-bit padded block and streams the 64 schedule words W0..W63, one per round, to the round datapath sequenced by the hash control block. It sits between the block/nonce assembly logic (upstream) and the compression rounds (downstream). It is used once per compression, i.e. twice per double-hash attempt.

## Interface
Parameters:
- NUM_ROUNDS, 64, number of schedule words emitted per block; fixed at 64 for SHA-256, not to be overridden.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  load `block_in` and begin streaming; honoured only in IDLE
- block_in  in  512  padded message block; word 0 = bits [511:480] (big-endian word order)
- stall  in  1  hold the current word; do not advance
- w_valid  out  1  `w_out`/`round_idx` carry a valid schedule word
- w_out  out  32  current schedule word W[t]
- round_idx  out  6  t of `w_out`, 0..63
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse after W63 is consumed

Clocking: one clock; reset is asynchronous and active-low.

## Operation
- Internal 16-word window `win[0..15]`; `win[0]` drives `w_out`.
- States:
  - **IDLE**: `start=1` → load `win[i] = block_in[511-32i -: 32]`, t=0, go to RUN.
  - **RUN**: `w_valid=1`. When `stall=0`:
    - if t=63 → DONE;
    - else shift `win[i]=win[i+1]` for i<15, set `win[15]=new`, t=t+1.
    - When `stall=1`, all state holds.
  - **DONE**: `done=1`, `w_valid=0` for one cycle → IDLE.
- Window update: `new = σ1(win[14]) + win[9] + σ0(win[1]) + win[0]`, mod 2^32, with carries dropped. This equals W[t+16] while W[t] is in `win[0]`.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10
- New words are computed and pushed during t=0..47 only; pushes for t≥48 are don't-care. No extra words are emitted.
- `start` in RUN or DONE is ignored. It is not queued.
- `start` and `stall` together in IDLE: the load occurs; `stall` has no effect until RUN.
- `stall` in DONE is ignored; DONE always lasts exactly one cycle.
- `reset_n` low at any time, including mid-RUN: immediately IDLE. The partial stream is discarded and no `done` is issued.

## Timing
- Reset values: `w_valid=0`, `w_out=0`, `round_idx=0`, `busy=0`, `done=0`, window cleared.
- `start` sampled at edge k → `w_valid=1`, `w_out=W0`, `round_idx=0` valid after edge k (cycle k+1).
- Without stalls, W[t] is presented in cycle k+1+t. `done` is high in cycle k+65, and `start` is accepted again from that cycle's closing edge (cycle k+66 at the earliest).
- Each active stall cycle adds exactly one cycle of latency.
- Outputs are registered, with no combinational path from `stall` or `start` to outputs.
- `w_out` holds its last value in IDLE and DONE; consumers qualify it with `w_valid`.
- `busy` equals the state being RUN.

## Structure
- `sha256_pkg` (shared with the round datapath and control) holds:
  - `word_t` (logic [31:0]) and `block_t` (logic [511:0]);
  - the `NUM_ROUNDS` constant;
  - `sigma0`/`sigma1` functions (the round datapath adds `Sigma0`/`Sigma1`, `ch`, `maj` there);
  - the state enum `sched_state_e` {IDLE, RUN, DONE}.
- No sub-module. σ functions are package functions; the 4-input adder is inline.

## Test plan
- Block = FIPS 180-4 "abc" padded block (`61626380_0…0_00000018`), no stall:
  - W0=61626380, W1..W14=0, W15=00000018;
  - W16=61626380, W17=000F0000, W18=7DA86405, W63=12B1EDEB;
  - `done` exactly at cycle 65 after `start`.
- All-zero block → all 64 words 0, `round_idx` 0..63 in order, single `done` pulse.
- "abc" block with `stall` high for 3 cycles at t=16 and 1 cycle at t=63:
  - `w_out=61626380` held for 4 cycles at t=16;
  - W17 follows;
  - `done` 4 cycles later than the no-stall run.
- `start` pulsed at t=10 and in the DONE cycle → stream unaffected, no restart; a fresh `start` in the following IDLE cycle restarts normally.
- `reset_n` low at t=30 → `w_valid`, `busy`, `done` drop to 0 asynchronously; after release, a new "abc" run reproduces the golden sequence.
- Back-to-back blocks (the second started in the cycle after `done`) → both 64-word sequences correct, with exactly one idle cycle between them.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and the message-schedule sigma functions.
// The round datapath adds its own Sigma0/Sigma1, ch and maj next to these.
package sha256_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [511:0] block_t;

  localparam int NUM_ROUNDS = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one padded block and streams W0..W63,
// expanding a 16-word window in place as each word is consumed.
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         stall,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   round_idx,
  output logic         busy,
  output logic         done
);
  import sha256_pkg::*;

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  sched_state_e state_q, state_d;
  word_t        win_q [16];
  logic [5:0]   t_q;
  logic         load;
  logic         advance;
  word_t        w_new;

  // W[t+16] while W[t] sits in win[0]; carries beyond 32 bits are dropped.
  assign w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (t_q == LAST_T) state_d = DONE;
          else               advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        for (int i = 0; i < 16; i++) win_q[i] <= block_in[511 - 32*i -: 32];
        t_q <= '0;
      end else if (advance) begin
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
        win_q[15] <= w_new;
        t_q       <= t_q + 6'd1;
      end
    end
  end

  // Every output comes straight from a register: no path from start/stall.
  assign w_out     = win_q[0];
  assign round_idx = t_q;
  assign w_valid   = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed scoreboard bench for sha256_msg_schedule.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [511:0] block_in;
  logic         stall;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   round_idx;
  logic         busy;
  logic         done;

  sha256_msg_schedule dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .block_in  (block_in),
    .stall     (stall),
    .w_valid   (w_valid),
    .w_out     (w_out),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   done_cyc = -100;
  bit   gold_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Standard FIPS recurrence over a flat 64-entry array.
  task automatic push_block(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.w   = w[t];
      e.idx = 6'(t);
      sb.push_back(e);
    end
  endtask

  // Published "abc" schedule words.
  function automatic bit gold_word(input logic [5:0] idx, output logic [31:0] v);
    v = 32'h0;
    if (idx == 6'd0)                     begin v = 32'h61626380; return 1'b1; end
    if (idx >= 6'd1 && idx <= 6'd14)     begin v = 32'h00000000; return 1'b1; end
    if (idx == 6'd15)                    begin v = 32'h00000018; return 1'b1; end
    if (idx == 6'd16)                    begin v = 32'h61626380; return 1'b1; end
    if (idx == 6'd17)                    begin v = 32'h000F0000; return 1'b1; end
    if (idx == 6'd18)                    begin v = 32'h7DA86405; return 1'b1; end
    if (idx == 6'd63)                    begin v = 32'h12B1EDEB; return 1'b1; end
    return 1'b0;
  endfunction

  // Drive inputs for the current cycle, check what the DUT presents now,
  // retire the scoreboard head if the word is consumed at the coming edge.
  task automatic step(input logic st, input logic sl);
    logic [31:0] g;
    start = st;
    stall = sl;
    if (w_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word_idx", {26'd0, round_idx}, 32'hFFFF_FFFF);
      end else begin
        chk("w_out", w_out, sb[0].w);
        chk("round_idx", {26'd0, round_idx}, {26'd0, sb[0].idx});
        if (gold_en && gold_word(round_idx, g)) chk("abc_golden", w_out, g);
        if (!sl) void'(sb.pop_front());
      end
      chk("busy_in_run", {31'd0, busy}, 32'd1);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      chk("valid_in_done", {31'd0, w_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [511:0] blk, input int s16, input int s63,
                           input bit pulse, input int abort_at, input bit b2b, input bit gold);
    int   start_cyc, first_vld, nd0, prev_done, l16, l63;
    bit   fin;
    logic st, sl;
    l16 = s16;
    l63 = s63;
    prev_done = done_cyc;
    push_block(blk);
    gold_en   = gold;
    block_in  = blk;
    start_cyc = cyc;
    nd0       = n_done;
    first_vld = -1;
    fin       = 1'b0;
    step(1'b1, (s16 > 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 300 && !fin; i++) begin
      st = 1'b0;
      sl = 1'b0;
      if (w_valid && first_vld < 0) first_vld = cyc;
      if (abort_at >= 0 && w_valid && round_idx == 6'(abort_at)) begin
        reset_n = 1'b0;
        #1;
        chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        chk("rst_round_idx", {26'd0, round_idx}, 32'd0);
        sb.delete();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (70) step(1'b0, 1'b0);
        chk("no_done_after_abort", n_done - nd0, 0);
        chk("idle_after_abort", {31'd0, w_valid}, 32'd0);
        fin = 1'b1;
      end else begin
        if (w_valid && round_idx == 6'd16 && l16 > 0) begin sl = 1'b1; l16--; end
        if (w_valid && round_idx == 6'd63 && l63 > 0) begin sl = 1'b1; l63--; end
        if (pulse && ((w_valid && round_idx == 6'd10) || done)) st = 1'b1;
        if (pulse && done) sl = 1'b1;
        if (done) fin = 1'b1;
        step(st, sl);
      end
    end
    gold_en = 1'b0;
    if (abort_at < 0) begin
      chk("done_count", n_done - nd0, 1);
      chk("done_cycle", done_cyc - start_cyc, 65 + s16 + s63);
      chk("sb_drained", sb.size(), 0);
      chk("first_valid_latency", first_vld - start_cyc, 1);
      if (b2b) chk("one_idle_gap", first_vld - prev_done, 2);
    end
  endtask

  logic [511:0] abc_blk;
  logic [511:0] rnd_blk;

  initial begin
    abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
    reset_n  = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    block_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_w_valid", {31'd0, w_valid}, 32'd0);
    chk("reset_w_out", w_out, 32'd0);
    chk("reset_round_idx", {26'd0, round_idx}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    step(1'b0, 1'b0);

    run_block(abc_blk, 0, 0, 1'b0, -1, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("w_out_holds_idle", w_out, 32'h12B1EDEB);

    run_block('0, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    step(1'b0, 1'b0);

    run_block(abc_blk, 3, 1, 1'b0, -1, 1'b0, 1'b1);
    step(1'b0, 1'b0);

    run_block(abc_blk, 0, 0, 1'b1, -1, 1'b0, 1'b1);
    run_block(abc_blk, 0, 0, 1'b0, -1, 1'b1, 1'b1);
    step(1'b0, 1'b0);

    run_block(abc_blk, 0, 0, 1'b0, 30, 1'b0, 1'b0);
    run_block(abc_blk, 0, 0, 1'b0, -1, 1'b0, 1'b1);
    step(1'b0, 1'b0);

    for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom;
    run_block(rnd_blk, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    run_block(abc_blk, 0, 0, 1'b0, -1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
